// File: rtl/dm_bus_arbiter.sv
// dm_bus_arbiter: shares one single-ported data memory between the CPU data
// port (M0) and a secondary master (M1). M0 has default priority; M1 gets a
// forced grant once it has waited STARVE_LIMIT-1 cycles in a row. One access
// is issued per cycle, and read data is steered back to its issuer one cycle
// later.
module dm_bus_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_byteen,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_byteen,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,

    output logic        s_en,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_byteen,
    input  logic [31:0] s_rdata,

    output logic [3:0]  starve_cnt
);

    // Wait count at which M1 overrides M0; also the saturation point.
    localparam logic [3:0] CNT_MAX = 4'(STARVE_LIMIT - 1);

    logic [3:0] starve_q;
    logic [1:0] rd_owner;   // bit i: master i issued a read last cycle
    logic       force_m1;
    logic       gnt0;
    logic       gnt1;

    // Grant selection: starvation override first, then M0, then M1.
    // Everything is suppressed while reset is high.
    always_comb begin
        force_m1 = (starve_q == CNT_MAX) && m1_req;
        gnt1     = !reset && m1_req && (force_m1 || !m0_req);
        gnt0     = !reset && m0_req && !gnt1;
    end

    // Memory port mirrors the granted master's payload, zero when idle.
    always_comb begin
        s_en     = gnt0 || gnt1;
        s_addr   = 32'd0;
        s_wdata  = 32'd0;
        s_byteen = 4'd0;
        if (gnt1) begin
            s_addr   = m1_addr;
            s_wdata  = m1_wdata;
            s_byteen = m1_byteen;
        end else if (gnt0) begin
            s_addr   = m0_addr;
            s_wdata  = m0_wdata;
            s_byteen = m0_byteen;
        end
    end

    // Read return steering; a read in flight across reset is dropped.
    always_comb begin
        m0_gnt     = gnt0;
        m1_gnt     = gnt1;
        m0_rvalid  = rd_owner[0] && !reset;
        m1_rvalid  = rd_owner[1] && !reset;
        m0_rdata   = m0_rvalid ? s_rdata : 32'd0;
        m1_rdata   = m1_rvalid ? s_rdata : 32'd0;
        starve_cnt = starve_q;
    end

    // Starvation counter and read-owner tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= 4'd0;
            rd_owner <= 2'b00;
        end else begin
            if (gnt1 || !m1_req) begin
                starve_q <= 4'd0;
            end else if (starve_q < CNT_MAX) begin
                starve_q <= starve_q + 4'd1;
            end
            rd_owner <= {gnt1 && (m1_byteen == 4'd0), gnt0 && (m0_byteen == 4'd0)};
        end
    end

endmodule
